rx_word_packer: RTL and testbench
=================================

Name: rx_word_packer

Overview:
- Sits directly downstream of the debugger UART receiver.
- Consumes each received byte (the receiver's one-cycle done pulse plus its data byte) and packs BYTES_PER_WORD consecutive bytes, little-endian, into one word.
- Presents the word to the debugger command logic through a valid/ready handshake with a one-entry output buffer.
- Discards stale partial words after an inter-byte silence timeout, measured in receiver sample ticks.

Parameters:
- LEN_DATA, 8, bits per received byte.
- BYTES_PER_WORD, 4, bytes per packed word (2..8).
- CNT_W, 3, width of byte counter; must hold BYTES_PER_WORD-1.
- TIMEOUT_TICKS, 480, s_tick periods of silence allowed mid-word (3 frame times at 16x oversampling).
- TO_W, 9, width of timeout counter; must hold TIMEOUT_TICKS-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous reset, active-high.
- s_tick  in  1  16x-baud sample tick, the same tick that feeds the receiver.
- rx_done  in  1  one-cycle pulse: din holds a new byte.
- din  in  LEN_DATA  received byte, valid when rx_done=1.
- word_out  out  BYTES_PER_WORD*LEN_DATA  packed word; byte 0 occupies [LEN_DATA-1:0].
- word_valid  out  1  word_out holds an untransferred word.
- word_ready  in  1  consumer accepts word_out this cycle.
- byte_cnt  out  CNT_W  bytes of the current partial word already stored.
- overrun  out  1  sticky: a completed word was dropped because the buffer was full.
- timeout  out  1  one-cycle pulse: a partial word was discarded.
- clr_err  in  1  clears overrun.

Behaviour:
- Reset: all of the following are 0:
  - state, byte_cnt, shift register, timeout counter;
  - word_out, word_valid, overrun, timeout.
- Reset is async on assertion; the first active edge after release operates normally.
- Reset mid-word or with word_valid=1 drops everything silently; no timeout pulse.
- FSM states:
  - IDLE: byte_cnt=0. rx_done with BYTES_PER_WORD>1 stores din in lane 0, sets byte_cnt=1 and moves to ASSEMBLE.
  - ASSEMBLE: rx_done stores din in lane byte_cnt, then byte_cnt+1.
    - If the stored byte was lane BYTES_PER_WORD-1, the word is complete: byte_cnt returns to 0, the shift register clears, and the FSM returns to IDLE.
- Bytes are packed positionally by lane, so earlier lanes are never shifted.
- Word completion:
  - If word_valid=0, or word_valid=1 with word_ready=1 in the same cycle, then on the next edge the assembled word (including the current din) goes to word_out and word_valid=1.
  - Latency: word_valid rises 1 cycle after the final rx_done.
  - Otherwise the completed word is dropped, word_out is unchanged, and overrun is set.
- Handshake:
  - Transfer occurs on an edge where word_valid=1 and word_ready=1.
  - After a transfer, word_valid=0 unless a new word loads on that same edge, in which case word_valid stays 1 with the new data.
  - word_out is stable while word_valid=1 and no transfer occurs.
  - word_ready is ignored while word_valid=0.
- Timeout:
  - The counter runs only in ASSEMBLE and increments on s_tick.
  - It is cleared by rx_done, by entering IDLE and by reset.
  - When s_tick arrives with the counter at TIMEOUT_TICKS-1 and no rx_done: byte_cnt=0, shift register cleared, FSM to IDLE, timeout=1 for exactly one cycle.
  - rx_done and expiry in the same cycle: rx_done wins, the byte is stored and the counter clears.
  - The output buffer is never affected by timeout.
- overrun is set on a drop and cleared by clr_err. Set wins when both occur in the same cycle.
- A byte arriving while word_valid=1 is accepted normally; only a word that completes against a full buffer is dropped.
- Arithmetic: byte_cnt and the timeout counter are unsigned and never wrap; both are explicitly reset at their terminal values.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, ASSEMBLE);
  - default LEN_DATA and BYTES_PER_WORD, shared with the debugger command decoder;
  - TIMEOUT_TICKS default.
- One natural sub-module: rx_idle_timer. It contains the TO_W counter with inputs clk, rst, enable, clear and s_tick, and a one-cycle expire output.

Test Plan:
- Four bytes 0x11,0x22,0x33,0x44 with word_ready=1 -> one cycle after the 4th rx_done: word_valid=1, word_out=0x44332211, byte_cnt=0; transfer on the next edge; overrun=0.
- word_ready=0, send 8 bytes 0x01..0x08 -> word_out holds 0x04030201 throughout; overrun=1 one cycle after the 8th rx_done; clr_err pulse -> overrun=0.
- word_valid=1 holding 0x04030201; 4th byte of 0x08070605 arrives with word_ready=1 in the same cycle -> next cycle word_valid stays 1, word_out=0x08070605, overrun=0.
- Send 2 bytes, then 480 s_ticks with no rx_done -> on the 480th tick edge: timeout pulses for 1 cycle, byte_cnt=0; the next 4 bytes 0xA0..0xA3 yield 0xA3A2A1A0.
- rx_done coincides with the 480th s_tick -> no timeout pulse; byte stored, byte_cnt increments.
- Assert rst after 3 bytes and while word_valid=1 -> immediately: word_valid=0, byte_cnt=0, overrun=0, timeout=0; a following 4-byte sequence packs correctly.

Source files
------------

// File: rtl/rx_word_packer_pkg.sv
// rtl/rx_word_packer_pkg.sv - shared types and defaults for the UART receive word packer
package rx_word_packer_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_ASSEMBLE = 1'b1
  } pack_state_t;

  // The debugger command decoder sizes its word fields from these.
  localparam int DEF_LEN_DATA       = 8;
  localparam int DEF_BYTES_PER_WORD = 4;
  localparam int DEF_CNT_W          = 3;

  // Three frame times at 16x oversampling.
  localparam int DEF_TIMEOUT_TICKS  = 480;
  localparam int DEF_TO_W           = 9;

endpackage

// File: rtl/rx_word_packer_idle_timer.sv
// rtl/rx_word_packer_idle_timer.sv - inter-byte silence timer counted in sample ticks
module rx_idle_timer
  import rx_word_packer_pkg::*;
#(
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int TO_W          = DEF_TO_W
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  input  logic s_tick,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_TICKS - 1);

  logic [TO_W-1:0] cnt;

  // A clear in the same cycle as the terminal tick suppresses the expiry.
  always_comb begin
    expire = enable && !clear && s_tick && (cnt == LAST_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (s_tick) begin
      if (cnt == LAST_CNT) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + TO_W'(1);
      end
    end
  end

endmodule

// File: rtl/rx_word_packer.sv
// rtl/rx_word_packer.sv - packs received UART bytes little-endian into words
// with a one-entry valid/ready output buffer and a mid-word silence timeout.
module rx_word_packer
  import rx_word_packer_pkg::*;
#(
  parameter int LEN_DATA       = DEF_LEN_DATA,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_TICKS  = DEF_TIMEOUT_TICKS,
  parameter int TO_W           = DEF_TO_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_tick,
  input  logic                               rx_done,
  input  logic [LEN_DATA-1:0]                din,
  output logic [BYTES_PER_WORD*LEN_DATA-1:0] word_out,
  output logic                               word_valid,
  input  logic                               word_ready,
  output logic [CNT_W-1:0]                   byte_cnt,
  output logic                               overrun,
  output logic                               timeout,
  input  logic                               clr_err
);

  localparam int WORD_W = BYTES_PER_WORD * LEN_DATA;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES_PER_WORD - 1);

  pack_state_t       state;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] word_next;
  logic              last_lane;
  logic              can_load;
  logic              to_enable;
  logic              to_clear;
  logic              to_expire;

  // Lane insertion is positional: earlier lanes are never moved.
  always_comb begin
    word_next = shift_reg;
    word_next[int'(byte_cnt)*LEN_DATA +: LEN_DATA] = din;
  end

  always_comb begin
    last_lane = (byte_cnt == LAST_LANE);
    can_load  = !word_valid || word_ready;
    to_enable = (state == ST_ASSEMBLE);
    to_clear  = rx_done || (state != ST_ASSEMBLE);
  end

  rx_idle_timer #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .TO_W          (TO_W)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (to_enable),
    .clear  (to_clear),
    .s_tick (s_tick),
    .expire (to_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      shift_reg  <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (clr_err) begin
        overrun <= 1'b0;
      end
      if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      // Later assignments below take priority over the defaults above,
      // so a fresh load keeps word_valid high and a drop beats clr_err.
      case (state)
        ST_IDLE: begin
          if (rx_done) begin
            shift_reg[LEN_DATA-1:0] <= din;
            byte_cnt                <= CNT_W'(1);
            state                   <= ST_ASSEMBLE;
          end
        end

        ST_ASSEMBLE: begin
          if (rx_done) begin
            if (last_lane) begin
              byte_cnt  <= '0;
              shift_reg <= '0;
              state     <= ST_IDLE;
              if (can_load) begin
                word_out   <= word_next;
                word_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              shift_reg <= word_next;
              byte_cnt  <= byte_cnt + CNT_W'(1);
            end
          end else if (to_expire) begin
            byte_cnt  <= '0;
            shift_reg <= '0;
            state     <= ST_IDLE;
            timeout   <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_word_packer.sv
// tb/tb_rx_word_packer.sv - self-checking bench for rx_word_packer
module tb_rx_word_packer;

  localparam int LEN_DATA = 8;
  localparam int BPW      = 4;
  localparam int CNT_W    = 3;
  localparam int TO_TICKS = 480;
  localparam int TO_W     = 9;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    s_tick = 1'b0;
  logic                    rx_done = 1'b0;
  logic [LEN_DATA-1:0]     din = '0;
  logic [BPW*LEN_DATA-1:0] word_out;
  logic                    word_valid;
  logic                    word_ready = 1'b0;
  logic [CNT_W-1:0]        byte_cnt;
  logic                    overrun;
  logic                    timeout;
  logic                    clr_err = 1'b0;

  int checks = 0;
  int errors = 0;

  rx_word_packer #(
    .LEN_DATA       (LEN_DATA),
    .BYTES_PER_WORD (BPW),
    .CNT_W          (CNT_W),
    .TIMEOUT_TICKS  (TO_TICKS),
    .TO_W           (TO_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_tick     (s_tick),
    .rx_done    (rx_done),
    .din        (din),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .byte_cnt   (byte_cnt),
    .overrun    (overrun),
    .timeout    (timeout),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: partial word as a byte queue, buffer as a value+flag.
  logic [7:0]  mq[$];
  int          tick_cnt = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_word = '0;
  logic        m_overrun = 1'b0;
  logic        m_timeout = 1'b0;

  initial begin
    logic [31:0] w;
    logic        load;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        tick_cnt  = 0;
        m_valid   = 1'b0;
        m_word    = '0;
        m_overrun = 1'b0;
        m_timeout = 1'b0;
      end else begin
        m_timeout = 1'b0;
        load = 1'b0;
        if (clr_err) m_overrun = 1'b0;
        if (rx_done) begin
          mq.push_back(din);
          tick_cnt = 0;
          if (mq.size() == BPW) begin
            w = '0;
            for (int i = 0; i < BPW; i++) w = w | (32'(mq[i]) << (8 * i));
            mq.delete();
            if (!m_valid || word_ready) begin
              m_word = w;
              load   = 1'b1;
            end else begin
              m_overrun = 1'b1;
            end
          end
        end else if (mq.size() > 0 && s_tick) begin
          tick_cnt++;
          if (tick_cnt == TO_TICKS) begin
            mq.delete();
            m_timeout = 1'b1;
          end
        end
        if (mq.size() == 0) tick_cnt = 0;
        if (load) m_valid = 1'b1;
        else if (m_valid && word_ready) m_valid = 1'b0;
      end
      #1;
      check("model word_valid", 64'(word_valid), 64'(m_valid));
      check("model word_out", 64'(word_out), 64'(m_word));
      check("model byte_cnt", 64'(byte_cnt), 64'(mq.size()));
      check("model overrun", 64'(overrun), 64'(m_overrun));
      check("model timeout", 64'(timeout), 64'(m_timeout));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    din     = b;
    @(negedge clk);
    rx_done = 1'b0;
    din     = '0;
  endtask

  task automatic tick_once();
    @(negedge clk);
    s_tick = 1'b1;
    @(negedge clk);
    s_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset word_valid", 64'(word_valid), 64'd0);
    check("reset word_out", 64'(word_out), 64'd0);
    check("reset byte_cnt", 64'(byte_cnt), 64'd0);
    check("reset overrun", 64'(overrun), 64'd0);
    check("reset timeout", 64'(timeout), 64'd0);
    rst = 1'b0;

    // Basic packing with consumer ready.
    word_ready = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check("t1 word_valid", 64'(word_valid), 64'd1);
    check("t1 word_out", 64'(word_out), 64'h44332211);
    check("t1 byte_cnt", 64'(byte_cnt), 64'd0);
    @(negedge clk);
    check("t1 transfer", 64'(word_valid), 64'd0);
    check("t1 overrun", 64'(overrun), 64'd0);

    // Full buffer: second word is dropped.
    word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i));
      if (i >= 4) check("t2 word_out held", 64'(word_out), 64'h04030201);
      if (i == 7) check("t2 no overrun yet", 64'(overrun), 64'd0);
    end
    check("t2 overrun", 64'(overrun), 64'd1);
    check("t2 word_valid", 64'(word_valid), 64'd1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t2 clr_err", 64'(overrun), 64'd0);

    // Load and transfer on the same edge.
    send_byte(8'h05);
    send_byte(8'h06);
    send_byte(8'h07);
    check("t3 old word held", 64'(word_out), 64'h04030201);
    @(negedge clk);
    rx_done    = 1'b1;
    din        = 8'h08;
    word_ready = 1'b1;
    @(negedge clk);
    rx_done    = 1'b0;
    word_ready = 1'b0;
    check("t3 word_valid", 64'(word_valid), 64'd1);
    check("t3 word_out", 64'(word_out), 64'h08070605);
    check("t3 overrun", 64'(overrun), 64'd0);
    @(negedge clk);
    word_ready = 1'b1;
    @(negedge clk);
    check("t3 drained", 64'(word_valid), 64'd0);

    // Timeout discards a partial word.
    send_byte(8'hE0);
    send_byte(8'hE1);
    for (int i = 1; i <= TO_TICKS; i++) begin
      tick_once();
      if (i == TO_TICKS - 1) check("t4 no early timeout", 64'(timeout), 64'd0);
    end
    check("t4 timeout", 64'(timeout), 64'd1);
    check("t4 byte_cnt", 64'(byte_cnt), 64'd0);
    @(negedge clk);
    check("t4 timeout width", 64'(timeout), 64'd0);
    send_byte(8'hA0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    check("t4 word_out", 64'(word_out), 64'hA3A2A1A0);
    check("t4 word_valid", 64'(word_valid), 64'd1);

    // rx_done on the expiring tick wins.
    send_byte(8'hB0);
    for (int i = 1; i < TO_TICKS; i++) tick_once();
    @(negedge clk);
    rx_done = 1'b1;
    din     = 8'hB1;
    s_tick  = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    s_tick  = 1'b0;
    check("t5 no timeout", 64'(timeout), 64'd0);
    check("t5 byte_cnt", 64'(byte_cnt), 64'd2);
    send_byte(8'hB2);
    send_byte(8'hB3);
    check("t5 word_out", 64'(word_out), 64'hB3B2B1B0);

    // Reset mid-word with a pending word.
    @(negedge clk);
    word_ready = 1'b0;
    send_byte(8'hC0);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    send_byte(8'hD0);
    send_byte(8'hD1);
    send_byte(8'hD2);
    check("t6 pre byte_cnt", 64'(byte_cnt), 64'd3);
    check("t6 pre word_valid", 64'(word_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6 rst word_valid", 64'(word_valid), 64'd0);
    check("t6 rst byte_cnt", 64'(byte_cnt), 64'd0);
    check("t6 rst overrun", 64'(overrun), 64'd0);
    check("t6 rst timeout", 64'(timeout), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    word_ready = 1'b1;
    send_byte(8'h5A);
    send_byte(8'h6B);
    send_byte(8'h7C);
    send_byte(8'h8D);
    check("t6 word_out", 64'(word_out), 64'h8D7C6B5A);
    check("t6 word_valid", 64'(word_valid), 64'd1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
